// File: rtl/game_pkg.sv
// Shared Breakout game definitions: FSM state codes, hit-emitter codes
// and the default life count used by both game_control and the scoreboard.
package game_pkg;

  localparam int DEF_LIVES = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    LOST  = 3'd3,
    WIN   = 3'd4,
    OVER  = 3'd5,
    PAUSE = 3'd6
  } game_state_t;

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_HIGH = 2'd1,
    H_GAP  = 2'd2
  } hit_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_control_if.sv
// Game-control bus: physics inputs (ball_out, block_collision, blocks_cleared)
// and scoreboard/physics outputs (start, endgame, hit_block, ball_enable, state, lives).
interface game_control_if #(
  parameter int LW = 4
);

  logic          ball_out;
  logic          block_collision;
  logic          blocks_cleared;
  logic          start;
  logic          endgame;
  logic          hit_block;
  logic          ball_enable;
  logic [2:0]    game_state;
  logic [LW-1:0] lives_left;

  modport master (
    input  ball_out, block_collision, blocks_cleared,
    output start, endgame, hit_block, ball_enable,
    output game_state, lives_left
  );

  modport slave (
    output ball_out, block_collision, blocks_cleared,
    input  start, endgame, hit_block, ball_enable,
    input  game_state, lives_left
  );

endinterface

// File: rtl/button_debounce.sv
// Start-button conditioner: 2-flop synchronizer, stability counter, press pulse.
// Ports: clock, reset (sync, active-high), btn (raw), press (1-cycle on debounced rise).
module button_debounce
  import game_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          db;
  logic [CW-1:0] cnt;

  // The debounced level only flips after sync2 has disagreed with it
  // for DB_CYCLES consecutive cycles; any bounce back restarts the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == C_LAST) begin
        db    <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_control.sv
// Breakout game-state controller: serve/play/loss/win/over sequencing,
// lives tracking and a stretched hit_block strobe for the scoreboard.
// Ports: clock, reset (sync, active-high), btn_start, bus (game_control_if.master).
// Optional: define GAME_CONTROL_PAUSE_EN to add a PAUSE state toggled by the button in PLAY.
module game_control
  import game_pkg::*;
#(
  parameter int LIVES       = DEF_LIVES,
  parameter int SERVE_DELAY = 25000000,
  parameter int HIT_HOLD    = 4,
  parameter int DB_CYCLES   = 500000,
  parameter int PEND_W      = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_start,
  game_control_if.master bus
);

  localparam int LW = $clog2(LIVES + 1);
  localparam int TW = cnt_w(SERVE_DELAY);
  localparam int HW = cnt_w(HIT_HOLD);
  localparam logic [TW-1:0] T_LAST = TW'(SERVE_DELAY - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HIT_HOLD - 1);
  localparam logic [LW-1:0] L_INIT = LW'(LIVES);
  localparam logic [LW-1:0] L_ONE  = LW'(1);
  localparam logic [PEND_W-1:0] P_MAX = '1;

  game_state_t     state_q, state_d;
  hit_state_t      hst_q, hst_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [LW-1:0]   lives_q, lives_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic            press;
  logic            start;
  logic            endgame;
  logic            ball_en;
  logic            acc;
  logic            fire;

  button_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db (
    .clock(clock),
    .reset(reset),
    .btn  (btn_start),
    .press(press)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      hst_q   <= H_IDLE;
      timer_q <= '0;
      hcnt_q  <= '0;
      lives_q <= L_INIT;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      hst_q   <= hst_d;
      timer_q <= timer_d;
      hcnt_q  <= hcnt_d;
      lives_q <= lives_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    lives_d = lives_q;
    start   = 1'b0;
    endgame = 1'b0;
    ball_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          state_d = SERVE;
          start   = 1'b1;
        end
      end
      SERVE: begin
        if (timer_q == T_LAST) state_d = PLAY;
        else timer_d = timer_q + 1'b1;
      end
      PLAY: begin
        ball_en = 1'b1;
        if (bus.ball_out) state_d = LOST;
        else if (bus.blocks_cleared) state_d = WIN;
`ifdef GAME_CONTROL_PAUSE_EN
        else if (press) state_d = PAUSE;
`endif
      end
      LOST: begin
        endgame = 1'b1;
        if (lives_q != '0) lives_d = lives_q - 1'b1;
        state_d = (lives_q <= L_ONE) ? OVER : SERVE;
      end
      WIN: begin
        if (press) begin
          state_d = SERVE;
          start   = 1'b1;
        end
      end
      OVER: state_d = OVER;
`ifdef GAME_CONTROL_PAUSE_EN
      PAUSE: begin
        if (press) state_d = PLAY;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // A new point may start straight out of the gap cycle, giving a
  // HIT_HOLD+1 period; LOST blocks it so flushed hits never leak out.
  always_comb begin
    acc    = bus.block_collision && (state_q == PLAY);
    fire   = ((hst_q == H_IDLE) || (hst_q == H_GAP)) &&
             (pend_q != '0) && (state_q != LOST);
    hst_d  = hst_q;
    hcnt_d = '0;
    pend_d = pend_q;
    if (state_q == LOST) pend_d = '0;
    else if (acc && !fire && pend_q != P_MAX) pend_d = pend_q + 1'b1;
    else if (fire && !acc) pend_d = pend_q - 1'b1;
    unique case (hst_q)
      H_HIGH: begin
        if (hcnt_q == H_LAST) hst_d = H_GAP;
        else hcnt_d = hcnt_q + 1'b1;
      end
      default: hst_d = fire ? H_HIGH : H_IDLE;
    endcase
  end

  assign bus.start       = start;
  assign bus.endgame     = endgame;
  assign bus.ball_enable = ball_en;
  assign bus.hit_block   = (hst_q == H_HIGH);
  assign bus.game_state  = state_q;
  assign bus.lives_left  = lives_q;

endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control with LIVES=3, SERVE_DELAY=8,
// HIT_HOLD=2, DB_CYCLES=4.
module tb_game_control;

  logic clock = 1'b0;
  logic reset;
  logic btn_start;

  always #5 clock = ~clock;

  game_control_if #(.LW(2)) bus ();

  game_control #(
    .LIVES      (3),
    .SERVE_DELAY(8),
    .HIT_HOLD   (2),
    .DB_CYCLES  (4),
    .PEND_W     (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_start(btn_start),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic wait_state(input int s, input int lim, input string tag);
    for (int i = 0; i < lim && int'(bus.game_state) != s; i++) tick();
    chk(tag, int'(bus.game_state), s);
  endtask

  task automatic press_for(input int n, output int starts, output int ends);
    starts = 0;
    ends   = 0;
    btn_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      starts += int'(bus.start);
      ends   += int'(bus.endgame);
    end
    btn_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      starts += int'(bus.start);
      ends   += int'(bus.endgame);
    end
  endtask

  initial begin
    int k, pe, st1, ns, ne, hits, rises, prev, st_lost, st_after;
    logic [11:0] pat;

    reset = 1'b1;
    btn_start = 1'b0;
    bus.ball_out = 1'b0;
    bus.block_collision = 1'b0;
    bus.blocks_cleared = 1'b0;
    repeat (3) tick();
    chk("rst_state", int'(bus.game_state), 0);
    chk("rst_lives", int'(bus.lives_left), 3);
    chk("rst_outs", int'({bus.start, bus.endgame,
                          bus.hit_block, bus.ball_enable}), 0);
    reset = 1'b0;
    tick();

    // held button: one start, SERVE for 8 cycles, then PLAY
    k = -1; pe = -1; st1 = -1; ns = 0;
    btn_start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.start) begin
        ns++;
        if (k < 0) begin
          k = i;
          chk("start_from_idle", int'(bus.game_state), 0);
        end
      end
      if (k >= 0 && i == k + 1) st1 = int'(bus.game_state);
      if (bus.ball_enable && pe < 0) begin
        pe = i;
        chk("play_state", int'(bus.game_state), 2);
      end
    end
    btn_start = 1'b0;
    chk("one_start", ns, 1);
    chk("serve_state", st1, 1);
    chk("serve_len", pe - (k + 1), 8);
    repeat (8) tick();

    // three back-to-back collisions: 110 repeated three times
    pat = '0;
    bus.block_collision = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      pat[i] = bus.hit_block;
      if (i == 2) bus.block_collision = 1'b0;
    end
    chk("hit_pattern", int'(pat), 438);

    // ball_out beats blocks_cleared
    bus.ball_out = 1'b1;
    bus.blocks_cleared = 1'b1;
    tick();
    chk("lost_state", int'(bus.game_state), 3);
    chk("lost_endgame", int'(bus.endgame), 1);
    chk("lost_nostart", int'(bus.start), 0);
    bus.ball_out = 1'b0;
    bus.blocks_cleared = 1'b0;
    tick();
    chk("reserve_state", int'(bus.game_state), 1);
    chk("lives_2", int'(bus.lives_left), 2);
    chk("reserve_nostart", int'(bus.start), 0);

    // collisions during SERVE are dropped
    hits = 0;
    bus.block_collision = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      hits += int'(bus.hit_block);
    end
    bus.block_collision = 1'b0;
    wait_state(2, 10, "play_again");
    repeat (4) begin
      tick();
      hits += int'(bus.hit_block);
    end
    chk("serve_drop", hits, 0);

    // five hits, ball lost right after the first point rises
    hits = 0; rises = 0; prev = 0; st_lost = -1; st_after = -1;
    bus.block_collision = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      hits += int'(bus.hit_block);
      if (bus.hit_block && prev == 0) rises++;
      prev = int'(bus.hit_block);
      if (i == 1) bus.ball_out = 1'b1;
      if (i == 2) begin
        st_lost = int'(bus.game_state);
        bus.ball_out = 1'b0;
      end
      if (i == 3) st_after = int'(bus.game_state);
      if (i == 4) bus.block_collision = 1'b0;
    end
    chk("flush_rises", rises, 1);
    chk("flush_high", hits, 2);
    chk("flush_lost", st_lost, 3);
    chk("flush_serve", st_after, 1);
    chk("lives_1", int'(bus.lives_left), 1);

    // win, collisions dropped, press re-serves with start
    wait_state(2, 12, "play_3");
    bus.blocks_cleared = 1'b1;
    tick();
    chk("win_state", int'(bus.game_state), 4);
    chk("win_ball_en", int'(bus.ball_enable), 0);
    bus.blocks_cleared = 1'b0;
    hits = 0;
    bus.block_collision = 1'b1;
    repeat (3) begin
      tick();
      hits += int'(bus.hit_block);
    end
    bus.block_collision = 1'b0;
    repeat (3) begin
      tick();
      hits += int'(bus.hit_block);
    end
    chk("win_drop", hits, 0);
    press_for(20, ns, ne);
    chk("win_start", ns, 1);
    wait_state(2, 20, "play_4");

`ifdef GAME_CONTROL_PAUSE_EN
    ne = 0;
    btn_start = 1'b1;
    wait_state(6, 20, "pause_enter");
    chk("pause_ball_en", int'(bus.ball_enable), 0);
    bus.ball_out = 1'b1;
    repeat (3) begin
      tick();
      ne += int'(bus.endgame);
    end
    chk("pause_hold", int'(bus.game_state), 6);
    bus.ball_out = 1'b0;
    btn_start = 1'b0;
    repeat (10) tick();
    btn_start = 1'b1;
    wait_state(2, 20, "pause_exit");
    btn_start = 1'b0;
    repeat (8) begin
      tick();
      ne += int'(bus.endgame);
    end
    chk("pause_no_end", ne, 0);
    chk("pause_back", int'(bus.game_state), 2);
`endif

    // last life lost -> OVER, presses ignored
    bus.ball_out = 1'b1;
    tick();
    chk("last_endgame", int'(bus.endgame), 1);
    bus.ball_out = 1'b0;
    tick();
    chk("over_state", int'(bus.game_state), 5);
    chk("lives_0", int'(bus.lives_left), 0);
    press_for(20, ns, ne);
    chk("over_nostart", ns, 0);
    chk("over_noend", ne, 0);
    chk("over_stays", int'(bus.game_state), 5);
    chk("over_lives", int'(bus.lives_left), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_control.md
Name: game_control

Overview:
- Breakout game-state controller; the event source that drives the scoreboard.
- Debounces the start button, sequences serve/play/loss/win/game-over, and tracks remaining lives.
- Emits the `start` and `endgame` pulses and a stretched `hit_block` level. The scoreboard counts one point per rising edge of `hit_block`.
- Sits between the ball/collision physics and the scoreboard.

Parameters:
- LIVES, 10, lives at reset; must equal the scoreboard's initial lives.
- SERVE_DELAY, 25000000, cycles the ball is held in SERVE before release.
- HIT_HOLD, 4, cycles `hit_block` stays high per point (>=1).
- DB_CYCLES, 500000, cycles `btn_start` must be stable to register.
- PEND_W, 4, width of the pending-hit counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- btn_start  in  1  raw push-button, active-high, asynchronous to clock
- ball_out  in  1  level: ball passed below the paddle
- block_collision  in  1  1-cycle pulse per destroyed block; may arrive back-to-back
- blocks_cleared  in  1  level: no blocks remain
- start  out  1  1-cycle pulse: new round begins
- endgame  out  1  1-cycle pulse: ball lost
- hit_block  out  1  point strobe, high HIT_HOLD cycles, then low >=1 cycle
- ball_enable  out  1  physics may move the ball
- game_state  out  3  current FSM state code
- lives_left  out  $clog2(LIVES+1)  remaining lives

Behaviour:
- Reset values: state IDLE; lives_left=LIVES; all 1-bit outputs 0; pending counter 0; timers 0.
- Button path:
  - 2-flop synchronizer, then debounce.
  - A press event is a 1-cycle pulse on the debounced 0->1 transition.
  - A held button yields exactly one event.
- FSM (one transition per cycle):
  - IDLE: press -> SERVE; `start`=1 on the transition cycle.
  - SERVE: ball_enable=0; timer counts 0..SERVE_DELAY-1; at SERVE_DELAY-1 -> PLAY with timer cleared.
  - PLAY: ball_enable=1.
    - ball_out -> LOST.
    - Else blocks_cleared -> WIN.
    - ball_out has priority when both are set.
  - LOST (1 cycle): `endgame`=1; lives_left decrements; pending counter cleared.
    - Next state OVER if the new lives_left==0, else SERVE.
    - No `start` pulse on re-serve.
  - WIN: ball_enable=0; press -> SERVE with a `start` pulse.
  - OVER: ball_enable=0; absorbing; only reset exits. Presses ignored.
- Hit path:
  - block_collision is accepted only in PLAY; elsewhere it is dropped.
  - Accepted collisions increment the pending counter, saturating at 2^PEND_W-1.
  - Emitter sub-FSM: H_IDLE -> H_HIGH (HIT_HOLD cycles) -> H_GAP (1 cycle) -> H_IDLE.
  - H_IDLE with pending>0: enter H_HIGH and decrement pending in the same cycle.
  - A collision and a decrement in the same cycle leave pending unchanged.
  - Guaranteed minimum period per point: HIT_HOLD+1 cycles.
  - The emitter finishes an in-progress H_HIGH/H_GAP even across LOST; only queued hits are flushed.
- `start` and `endgame` never assert in the same cycle.
- lives_left never underflows.
- Reset mid-operation: immediate return to reset values on the next edge, regardless of state.

Optional Feature:
- GAME_CONTROL_PAUSE_EN
  - Defined: a press in PLAY -> PAUSE state (code 6).
    - In PAUSE: ball_enable=0, collisions dropped, ball_out ignored; pending hits continue draining.
    - A press in PAUSE -> PLAY. No `start` or `endgame` pulses either way.
  - Undefined: PAUSE state is absent; a press in PLAY is ignored.

Decomposition:
- Package game_pkg:
  - State codes: IDLE=0, SERVE=1, PLAY=2, LOST=3, WIN=4, OVER=5, PAUSE=6.
  - Hit emitter state codes.
  - Default LIVES constant, shared with the scoreboard.
- One sub-module: button_debounce (synchronizer, stability counter, rising-edge pulse output; parameter DB_CYCLES).

Test Plan (LIVES=3, SERVE_DELAY=8, HIT_HOLD=2, DB_CYCLES=4):
- Reset, then hold btn_start 20 cycles -> exactly one `start` pulse; game_state 0->1; ball_enable rises 8 cycles later with game_state=2.
- In PLAY, 3 back-to-back block_collision pulses -> `hit_block` high 2 cycles, low 1 cycle, repeated 3 times (9 cycles total); pending reaches 0.
- In PLAY, ball_out=1 -> one-cycle `endgame`, lives_left 3->2, return to SERVE, no `start` pulse; repeat twice more -> lives_left=0, game_state=5; further presses produce nothing.
- Collisions in SERVE or WIN -> `hit_block` stays 0. ball_out and blocks_cleared in the same cycle -> LOST taken.
- 5 collisions, ball_out on the cycle after the first `hit_block` rise -> the current 2-cycle pulse completes, the remaining 4 are flushed, no further `hit_block`.
- With GAME_CONTROL_PAUSE_EN: press in PLAY -> state 6, ball_enable=0, ball_out ignored; press again -> state 2.
